// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_pkg.sv
// Shared definitions for the latrsnq register bank: priority encodings,
// default counter width and the per-channel next-state resolution.
package gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_pkg;

  // Value taken by a channel when clear and set are asserted together.
  localparam logic PRIO_RESET = 1'b0;
  localparam logic PRIO_SET   = 1'b1;

  // Default width of the saturating conflict counter.
  localparam int CNT_W_DEFAULT = 8;

  // Resolve one channel's next state.
  // Priority, highest first: both asserted -> prio, clear -> 0, set -> 1,
  // enable -> d, otherwise hold.
  function automatic logic resolve_next(
    input logic rn,
    input logic setn,
    input logic e,
    input logic d,
    input logic q,
    input logic prio
  );
    logic nxt;
    if ((rn == 1'b0) && (setn == 1'b0)) begin
      nxt = prio;
    end else if (rn == 1'b0) begin
      nxt = 1'b0;
    end else if (setn == 1'b0) begin
      nxt = 1'b1;
    end else if (e == 1'b1) begin
      nxt = d;
    end else begin
      nxt = q;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_if.sv
// Bus interface of the latrsnq register bank. The Q_PAR signal exists only
// when GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN is defined.
interface gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] RN;
  logic [WIDTH-1:0] SETN;
  logic             CLR_CONFLICT;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] CONFLICT;
  logic [CNT_W-1:0] CONFLICT_CNT;
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
  logic             Q_PAR;

  modport master (
    output E, D, RN, SETN, CLR_CONFLICT,
    input  Q, CONFLICT, CONFLICT_CNT, Q_PAR
  );

  modport slave (
    input  E, D, RN, SETN, CLR_CONFLICT,
    output Q, CONFLICT, CONFLICT_CNT, Q_PAR
  );
`else
  modport master (
    output E, D, RN, SETN, CLR_CONFLICT,
    input  Q, CONFLICT, CONFLICT_CNT
  );

  modport slave (
    input  E, D, RN, SETN, CLR_CONFLICT,
    output Q, CONFLICT, CONFLICT_CNT
  );
`endif

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_bit.sv
// One channel of the latrsnq bank: state register, optional output pipe
// register and sticky conflict flag. With
// GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN defined it also exposes the
// value its Q output will take on the next edge, so the parent can register
// parity in step with Q.
module gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_bit
  import gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_pkg::*;
#(
  parameter logic PRIO    = PRIO_RESET,
  parameter bit   PIPE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic e_i,
  input  logic d_i,
  input  logic rn_i,
  input  logic setn_i,
  input  logic clr_conflict_i,
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
  output logic q_nxt_o,
`endif
  output logic q_o,
  output logic conflict_o,
  output logic conflict_now_o
);

  logic state_q;
  logic state_d;
  logic flag_q;
  logic flag_d;
  logic conflict_now_s;

  // Conflict only when both controls are a clean 0; X/Z counts as not asserted.
  always_comb begin
    if ((rn_i == 1'b0) && (setn_i == 1'b0)) begin
      conflict_now_s = 1'b1;
    end else begin
      conflict_now_s = 1'b0;
    end
  end

  // Next channel state from the prioritised clear/set/enable rules.
  always_comb begin
    state_d = resolve_next(rn_i, setn_i, e_i, d_i, state_q, PRIO);
  end

  // Sticky flag: a new conflict beats a same-edge clear.
  always_comb begin
    if (conflict_now_s == 1'b1) begin
      flag_d = 1'b1;
    end else if (clr_conflict_i == 1'b1) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // State and conflict flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
    end
  end

  generate
    if (PIPE_EN) begin : g_pipe
      logic pipe_q;

      // Pipe register copies the state on every edge; it is never held.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_q <= 1'b0;
        end else begin
          pipe_q <= state_q;
        end
      end

      assign q_o = pipe_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
      assign q_nxt_o = state_q;
`endif
    end else begin : g_nopipe
      assign q_o = state_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
      assign q_nxt_o = state_d;
`endif
    end
  endgenerate

  assign conflict_o     = flag_q;
  assign conflict_now_o = conflict_now_s;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank.sv
// Parametrised bank of WIDTH set/reset channels with configurable set/reset
// priority, optional output pipe stage, sticky per-channel conflict flags and
// a saturating conflict-cycle counter.
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN adds
// a registered Q_PAR output aligned with Q.
// The interface instance must be built with the same WIDTH and CNT_W.
module gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank
  import gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SET_DOMINANT = 0,
  parameter int PIPE         = 1,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_if.slave bus
);

  localparam logic             PRIO     = (SET_DOMINANT != 0) ? PRIO_SET : PRIO_RESET;
  localparam bit               PIPE_EN  = (PIPE != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] conflict_s;
  logic [WIDTH-1:0] conflict_now_s;
  logic             any_conflict_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
  logic [WIDTH-1:0] q_nxt_s;
  logic             q_par_q;
  logic             q_par_d;
`endif

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_bit #(
        .PRIO    (PRIO),
        .PIPE_EN (PIPE_EN)
      ) u_bit (
        .clk_i          (CLK),
        .rst_i          (RST),
        .e_i            (bus.E[i]),
        .d_i            (bus.D[i]),
        .rn_i           (bus.RN[i]),
        .setn_i         (bus.SETN[i]),
        .clr_conflict_i (bus.CLR_CONFLICT),
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
        .q_nxt_o        (q_nxt_s[i]),
`endif
        .q_o            (q_s[i]),
        .conflict_o     (conflict_s[i]),
        .conflict_now_o (conflict_now_s[i])
      );
    end
  endgenerate

  // Any channel in conflict on this edge.
  always_comb begin
    any_conflict_s = |conflict_now_s;
  end

  // Counter next value: a new conflict beats a same-edge clear and restarts
  // the count at one; the count saturates instead of wrapping.
  always_comb begin
    if (any_conflict_s == 1'b1) begin
      if (bus.CLR_CONFLICT == 1'b1) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (bus.CLR_CONFLICT == 1'b1) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
  // Parity of the value Q takes on the next edge, so Q_PAR lands with Q.
  always_comb begin
    q_par_d = ^q_nxt_s;
  end

  // Parity output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_par_q <= 1'b0;
    end else begin
      q_par_q <= q_par_d;
    end
  end

  assign bus.Q_PAR = q_par_q;
`endif

  assign bus.Q            = q_s;
  assign bus.CONFLICT     = conflict_s;
  assign bus.CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank.sv
// Self-checking bench for the latrsnq bank. Two instances share one stimulus:
// dut0 (PIPE=1, SET_DOMINANT=0, CNT_W=4) and dut1 (PIPE=0, SET_DOMINANT=1,
// CNT_W=8). A behavioural model tracks both.
module tb_gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [W-1:0] e_v, d_v, rn_v, setn_v;
  logic clr_v;
  bit chk_en = 1'b0;
  int n_vec = 0;
  int n_bad = 0;

  gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_if #(.WIDTH(W), .CNT_W(4)) if0 ();
  gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank_if #(.WIDTH(W), .CNT_W(8)) if1 ();

  assign if0.E = e_v;  assign if0.D = d_v;  assign if0.RN = rn_v;
  assign if0.SETN = setn_v;  assign if0.CLR_CONFLICT = clr_v;
  assign if1.E = e_v;  assign if1.D = d_v;  assign if1.RN = rn_v;
  assign if1.SETN = setn_v;  assign if1.CLR_CONFLICT = clr_v;

  gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank #(
    .WIDTH(W), .SET_DOMINANT(0), .PIPE(1), .CNT_W(4)
  ) dut0 (.CLK(CLK), .RST(RST), .bus(if0));

  gf180mcu_fd_sc_mcu7t5v0__latrsnq_bank #(
    .WIDTH(W), .SET_DOMINANT(1), .PIPE(0), .CNT_W(8)
  ) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // m_cur: channel states, m_prev: states before the last edge.
  // Q is m_prev for a piped instance and m_cur otherwise.
  localparam bit [1:0] M_PIPE = 2'b01;  // bit k: instance k has PIPE=1
  localparam bit [1:0] M_SD   = 2'b10;  // bit k: instance k is set-dominant
  logic [W-1:0] m_cur [2];
  logic [W-1:0] m_prev[2];
  logic [W-1:0] m_flag[2];
  int           m_cnt [2];

  function automatic int cnt_max(int k);
    return (k == 0) ? 15 : 255;
  endfunction

  function automatic logic [W-1:0] model_next(logic [W-1:0] cur, bit sd,
      logic [W-1:0] rn, logic [W-1:0] setn, logic [W-1:0] e, logic [W-1:0] d);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      if (!rn[i] && !setn[i]) n[i] = sd;
      else if (!rn[i])        n[i] = 1'b0;
      else if (!setn[i])      n[i] = 1'b1;
      else if (e[i])          n[i] = d[i];
      else                    n[i] = cur[i];
    end
    return n;
  endfunction

  function automatic int model_cnt(int cnt, int mx, bit any, bit clr);
    int base;
    base = clr ? 0 : cnt;
    if (!any) return base;
    return (base + 1 > mx) ? mx : base + 1;
  endfunction

  function automatic logic [W-1:0] exp_q(int k);
    return M_PIPE[k] ? m_prev[k] : m_cur[k];
  endfunction

  // Model state update on each edge, cleared asynchronously by RST.
  always @(posedge CLK or posedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        m_cur[k] <= '0; m_prev[k] <= '0; m_flag[k] <= '0; m_cnt[k] <= 0;
      end else begin
        m_prev[k] <= m_cur[k];
        m_cur[k]  <= model_next(m_cur[k], M_SD[k], rn_v, setn_v, e_v, d_v);
        m_flag[k] <= (clr_v ? '0 : m_flag[k]) | (~rn_v & ~setn_v);
        m_cnt[k]  <= model_cnt(m_cnt[k], cnt_max(k), |(~rn_v & ~setn_v), clr_v);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("q0", 64'(if0.Q), 64'(exp_q(0)));
      check("conflict0", 64'(if0.CONFLICT), 64'(m_flag[0]));
      check("cnt0", 64'(if0.CONFLICT_CNT), 64'(m_cnt[0]));
      check("q1", 64'(if1.Q), 64'(exp_q(1)));
      check("conflict1", 64'(if1.CONFLICT), 64'(m_flag[1]));
      check("cnt1", 64'(if1.CONFLICT_CNT), 64'(m_cnt[1]));
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
      check("par0", 64'(if0.Q_PAR), 64'(^exp_q(0)));
      check("par1", 64'(if1.Q_PAR), 64'(^exp_q(1)));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q0"}, 64'(if0.Q), 64'h0);
    check({tag, "_q1"}, 64'(if1.Q), 64'h0);
    check({tag, "_cf0"}, 64'(if0.CONFLICT), 64'h0);
    check({tag, "_cf1"}, 64'(if1.CONFLICT), 64'h0);
    check({tag, "_cn0"}, 64'(if0.CONFLICT_CNT), 64'h0);
    check({tag, "_cn1"}, 64'(if1.CONFLICT_CNT), 64'h0);
  endtask

  initial begin
    e_v = 8'h00; d_v = 8'h00; rn_v = 8'hFF; setn_v = 8'hFF; clr_v = 1'b0;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    chk_en = 1'b1;
    check_all_zero("reset");

    // Conflict on bit 0, then load A5.
    rn_v = 8'hFE; setn_v = 8'hFE;
    step(1);
    rn_v = 8'hFF; setn_v = 8'hFF; e_v = 8'hFF; d_v = 8'hA5;
    step(1);
    e_v = 8'h00;
    step(1);
    check("pre_q0", 64'(if0.Q), 64'hA5);
    check("pre_q1", 64'(if1.Q), 64'hA5);
    check("pre_cf0", 64'(if0.CONFLICT), 64'h01);
    check("pre_cf1", 64'(if1.CONFLICT), 64'h01);

    // Asynchronous reset mid-cycle.
    RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    step(1);
    RST = 1'b0; e_v = 8'hFF; d_v = 8'h3C;
    step(1);
    check("lat_q1", 64'(if1.Q), 64'h3C);
    check("lat_q0_early", 64'(if0.Q), 64'h00);
    step(1);
    check("lat_q0", 64'(if0.Q), 64'h3C);

    // Set then clear-beats-enable.
    d_v = 8'h00;
    step(2);
    e_v = 8'h00; setn_v = 8'hFE;
    step(1);
    check("set_q1", 64'(if1.Q), 64'h01);
    setn_v = 8'hFF;
    step(1);
    check("set_q0", 64'(if0.Q), 64'h01);
    rn_v = 8'hFE; e_v = 8'hFF; d_v = 8'hFF;
    step(1);
    check("clr_q1", 64'(if1.Q), 64'hFE);
    rn_v = 8'hFF; e_v = 8'h00;
    step(1);
    check("clr_q0", 64'(if0.Q), 64'hFE);

    // Conflict on bit 3 for three cycles.
    rn_v = 8'hF7; setn_v = 8'hF7;
    step(3);
    check("c3_q0", 64'(if0.Q), 64'hF6);
    check("c3_q1", 64'(if1.Q), 64'hFE);
    check("c3_cf0", 64'(if0.CONFLICT), 64'h08);
    check("c3_cf1", 64'(if1.CONFLICT), 64'h08);
    check("c3_cn0", 64'(if0.CONFLICT_CNT), 64'd3);
    check("c3_cn1", 64'(if1.CONFLICT_CNT), 64'd3);
    rn_v = 8'hFF; setn_v = 8'hFF; clr_v = 1'b1;
    step(1);
    clr_v = 1'b0;
    check("clr_cn0", 64'(if0.CONFLICT_CNT), 64'd0);
    check("clr_cf1", 64'(if1.CONFLICT), 64'h00);

    // Saturation of the 4-bit counter.
    rn_v = 8'hF7; setn_v = 8'hF7;
    step(20);
    check("sat_cn0", 64'(if0.CONFLICT_CNT), 64'd15);
    check("sat_cn1", 64'(if1.CONFLICT_CNT), 64'd20);
    step(1);
    check("sat_hold_cn0", 64'(if0.CONFLICT_CNT), 64'd15);
    check("sat_cn1b", 64'(if1.CONFLICT_CNT), 64'd21);

    // Same-edge clear and new conflict on bit 5, then clear alone.
    rn_v = 8'hDF; setn_v = 8'hDF; clr_v = 1'b1;
    step(1);
    check("sim_cf0", 64'(if0.CONFLICT), 64'h20);
    check("sim_cn0", 64'(if0.CONFLICT_CNT), 64'd1);
    check("sim_cn1", 64'(if1.CONFLICT_CNT), 64'd1);
    rn_v = 8'hFF; setn_v = 8'hFF;
    step(1);
    clr_v = 1'b0;
    check("clr2_cf1", 64'(if1.CONFLICT), 64'h00);
    check("clr2_cn0", 64'(if0.CONFLICT_CNT), 64'd0);

    // Load 07 then 03 (parity 1 then 0).
    e_v = 8'hFF; d_v = 8'h07;
    step(1);
    check("p7_q1", 64'(if1.Q), 64'h07);
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
    check("p7_par1", 64'(if1.Q_PAR), 64'h1);
`endif
    d_v = 8'h03;
    step(1);
    check("p7_q0", 64'(if0.Q), 64'h07);
    check("p3_q1", 64'(if1.Q), 64'h03);
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
    check("p7_par0", 64'(if0.Q_PAR), 64'h1);
    check("p3_par1", 64'(if1.Q_PAR), 64'h0);
`endif
    step(1);
    check("p3_q0", 64'(if0.Q), 64'h03);
`ifdef GF180MCU_FD_SC_MCU7T5V0__LATRSNQ_BANK_PARITY_EN
    check("p3_par0", 64'(if0.Q_PAR), 64'h0);
`endif

    // Randomised traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        RST = 1'b1;
        #2 RST = 1'b0;
      end
      e_v    = 8'($urandom);
      d_v    = 8'($urandom);
      rn_v   = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      setn_v = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      clr_v  = ($urandom_range(0, 15) == 0);
      step(1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
